// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// param_sync_fifo : single-clock FIFO with fill count, almost flags and
//                   optional sticky overflow/underflow (macro FIFO_ERR_FLAGS_EN)
// Revision 1.0
// ============================================================================
module param_sync_fifo #(
   parameter int DEPTH    = 8,
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             w_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             r_en,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow,
   input  logic             err_clr
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    w_count_nxt;
   logic             w_wr_acc;
   logic             w_rd_acc;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Acceptance uses the registered flags, i.e. the pre-edge occupancy.
   assign w_wr_acc    = w_en & ~full;
   assign w_rd_acc    = r_en & ~empty;
   assign w_count_nxt = count + CW'(w_wr_acc) - CW'(w_rd_acc);

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   // Status flags are computed from the next count so they track count exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         count        <= '0;
         data_out     <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= (AF_LEVEL == 0);
         almost_empty <= 1'b1;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
            data_out <= r_mem[r_rd_ptr];
         end
         count        <= w_count_nxt;
         full         <= (w_count_nxt == CW'(DEPTH));
         empty        <= (w_count_nxt == '0);
         almost_full  <= (w_count_nxt >= CW'(AF_LEVEL));
         almost_empty <= (w_count_nxt <= CW'(AE_LEVEL));
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_en & full) begin
            overflow <= 1'b1;
         end else if (err_clr) begin
            overflow <= 1'b0;
         end
         if (r_en & empty) begin
            underflow <= 1'b1;
         end else if (err_clr) begin
            underflow <= 1'b0;
         end
      end
   end
`else
   logic w_unused_err_clr;
   assign w_unused_err_clr = err_clr;
   assign overflow         = 1'b0;
   assign underflow        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
// tb_param_sync_fifo : directed + random stimulus against a queue-based model
// Revision 1.0
// ============================================================================
module tb_param_sync_fifo;

   localparam int DEPTH    = 8;
   localparam int WIDTH    = 8;
   localparam int AF_LEVEL = 6;
   localparam int AE_LEVEL = 2;
   localparam int CW       = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             w_en;
   logic [WIDTH-1:0] data_in;
   logic             r_en;
   logic             err_clr;
   logic [WIDTH-1:0] data_out;
   logic             full, empty, almost_full, almost_empty;
   logic [CW-1:0]    count;
   logic             overflow, underflow;

   int n_total = 0;
   int n_bad   = 0;

   // reference model state
   logic [WIDTH-1:0] m_q[$];
   logic [WIDTH-1:0] m_dout;
   logic             m_ovf, m_udf;

   param_sync_fifo #(
      .DEPTH    (DEPTH),
      .WIDTH    (WIDTH),
      .AF_LEVEL (AF_LEVEL),
      .AE_LEVEL (AE_LEVEL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .w_en         (w_en),
      .data_in      (data_in),
      .r_en         (r_en),
      .data_out     (data_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   task automatic check_all(input string ctx);
      int sz;
      sz = m_q.size();
      check_val({ctx, ".count"},   32'(count),        32'(sz));
      check_val({ctx, ".full"},    32'(full),         32'(sz == DEPTH));
      check_val({ctx, ".empty"},   32'(empty),        32'(sz == 0));
      check_val({ctx, ".afull"},   32'(almost_full),  32'(sz >= AF_LEVEL));
      check_val({ctx, ".aempty"},  32'(almost_empty), 32'(sz <= AE_LEVEL));
      check_val({ctx, ".dout"},    32'(data_out),     32'(m_dout));
      check_val({ctx, ".ovf"},     32'(overflow),     32'(m_ovf));
      check_val({ctx, ".udf"},     32'(underflow),    32'(m_udf));
   endtask

   // Drive one clock of requests, advance the model on the edge, then check.
   task automatic cycle(input string ctx, input logic w, input logic r,
                        input logic [WIDTH-1:0] d, input logic clr);
      int  sz;
      logic wr_ok, rd_ok;
      w_en = w; r_en = r; data_in = d; err_clr = clr;
      @(posedge clk);
      sz    = m_q.size();
      wr_ok = w && (sz < DEPTH);
      rd_ok = r && (sz > 0);
      if (rd_ok) m_dout = m_q.pop_front();
      if (wr_ok) m_q.push_back(d);
`ifdef FIFO_ERR_FLAGS_EN
      if (w && sz == DEPTH) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
      if (r && sz == 0)     m_udf = 1'b1; else if (clr) m_udf = 1'b0;
`endif
      #1;
      check_all(ctx);
   endtask

   initial begin
      rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0; err_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      // fill with 0x01..0x08, then overfill
      for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b1, 1'b0, 8'(i), 1'b0);
      cycle("ovf_write", 1'b1, 1'b0, 8'hEE, 1'b0);
      cycle("ovf_hold", 1'b0, 1'b0, 8'h00, 1'b0);

      // simultaneous request on full: read only
      cycle("full_wr_rd", 1'b1, 1'b1, 8'hAA, 1'b0);
      cycle("refill", 1'b1, 1'b0, 8'h09, 1'b0);

      // drain
      for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1, 8'h00, 1'b0);
      cycle("udf_read", 1'b0, 1'b1, 8'h00, 1'b0);
      cycle("err_clr", 1'b0, 1'b0, 8'h00, 1'b1);
      cycle("clr_vs_udf", 1'b0, 1'b1, 8'h00, 1'b1);
      cycle("err_clr2", 1'b0, 1'b0, 8'h00, 1'b1);

      // simultaneous request on empty: write only
      cycle("empty_wr_rd", 1'b1, 1'b1, 8'h33, 1'b0);
      // count==1, both: old word out
      cycle("one_wr_rd", 1'b1, 1'b1, 8'h44, 1'b0);

      // wrap-around at count 3
      cycle("to3a", 1'b1, 1'b0, 8'h50, 1'b0);
      cycle("to3b", 1'b1, 1'b0, 8'h51, 1'b0);
      for (int i = 0; i < 20; i++) cycle("wrap", 1'b1, 1'b1, 8'($urandom), 1'b0);

      // random traffic
      for (int i = 0; i < 400; i++)
         cycle("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
               8'($urandom), 1'($urandom_range(0, 9) == 0));

      // reset mid-stream at count 5
      while (m_q.size() > 5) cycle("trim", 1'b0, 1'b1, 8'h00, 1'b0);
      while (m_q.size() < 5) cycle("grow", 1'b1, 1'b0, 8'($urandom), 1'b0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk);
      #1 rst = 1'b0;
      cycle("post_rst_wr", 1'b1, 1'b0, 8'h5A, 1'b0);
      cycle("post_rst_rd", 1'b0, 1'b1, 8'h00, 1'b0);
      check_val("post_rst_5a", 32'(data_out), 32'h5A);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
